// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master for the apbslave register bank.
// A valid/ready command becomes one APB SETUP + ACCESS transfer. The result
// comes back as a one-cycle rsp_valid pulse. A wait-state timeout aborts
// transfers to a slave that never raises pready.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    // The counter must be able to hold TIMEOUT. It keeps one bit when the
    // timeout is disabled so that its width is never zero.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The abort happens on the TIMEOUT-th low sample. At that point the
    // counter still holds the count of earlier low samples, which is TIMEOUT-1.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             timeout_hit_s;

    assign timeout_hit_s = (TIMEOUT != 0) && (wait_cnt_r == LAST_WAIT);

    // Transfer FSM with all command, APB and response outputs registered
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= {DATA_W{1'b0}};
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= {ADDR_W{1'b0}};
            pwdata     <= {DATA_W{1'b0}};
        end else begin
            // The response is a single-cycle pulse unless a branch below sets it.
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        state_r   <= SETUP;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                SETUP: begin
                    penable    <= 1'b1;
                    wait_cnt_r <= {CNT_W{1'b0}};
                    state_r    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        // Completion has priority over a timeout on the same edge.
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? {DATA_W{1'b0}} : prdata;
                        cmd_ready <= 1'b1;
                        state_r   <= IDLE;
                    end else if (timeout_hit_s) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= {DATA_W{1'b0}};
                        cmd_ready <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    cmd_ready <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master. It includes a small register-bank slave model
// with a programmable number of wait states. Expected responses and phase
// lengths are computed from the transfer rules with plain arithmetic.
module tb_apb_master;

    localparam int TMO = 16;

    logic        pclk, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        psel, penable, pwrite, pready;
    logic [7:0]  paddr;
    logic [15:0] pwdata, prdata;

    int n_checks = 0;
    int n_fail   = 0;

    // slave model state
    logic [15:0] slv_mem [256];
    logic        mem_clr;
    int          wait_n;
    int          access_cnt;
    // reference contents of the register bank
    logic [15:0] model_mem [256];

    apb_master #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // slave: pready rises after wait_n low ACCESS cycles
    assign pready = psel && penable && (access_cnt >= wait_n);
    assign prdata = slv_mem[paddr];

    // slave wait-state counter
    always @(posedge pclk) begin
        if (!(psel && penable)) access_cnt <= 0;
        else if (!pready)       access_cnt <= access_cnt + 1;
    end

    // slave register bank
    always @(posedge pclk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= 16'h0000;
        end else if (psel && penable && pready && pwrite) begin
            slv_mem[paddr] <= pwdata;
        end
    end

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!cmd_ready && t < 60) begin @(negedge pclk); t++; end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL %s_ready_wait: cmd_ready=%b required 1", tag, cmd_ready);
            n_fail++;
        end
    endtask

    // One complete transfer, with its phase lengths and response checked.
    task automatic run_xfer(input logic w, input logic [7:0] a, input logic [15:0] d,
                            input int wn, input string tag);
        int          exp_acc, psel_n, pen_n;
        logic        exp_err;
        logic [15:0] exp_rd;
        bit          seen, stable;
        wait_ready(tag);
        wait_n    = wn;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(negedge pclk);
        // The command port is garbage once the accept edge has passed.
        cmd_valid = 1'b0; cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom); cmd_wdata = 16'($urandom);
        exp_err = (wn >= TMO);
        exp_acc = exp_err ? TMO : wn + 1;
        exp_rd  = (w || exp_err) ? 16'h0000 : model_mem[a];
        psel_n = 0; pen_n = 0; seen = 0; stable = 1;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (rsp_valid) seen = 1;
            else begin
                if (psel) psel_n++;
                if (penable) pen_n++;
                if (paddr !== a || pwrite !== w || pwdata !== d) stable = 0;
                @(negedge pclk);
            end
        end
        n_checks += 8;
        if (!seen) begin
            $display("FAIL %s_rsp: no rsp_valid within bound, required one pulse", tag); n_fail++;
        end
        if (psel_n != exp_acc + 1) begin
            $display("FAIL %s_psel_len: psel cycles=%0d required %0d", tag, psel_n, exp_acc + 1); n_fail++;
        end
        if (pen_n != exp_acc) begin
            $display("FAIL %s_penable_len: penable cycles=%0d required %0d", tag, pen_n, exp_acc); n_fail++;
        end
        if (!stable) begin
            $display("FAIL %s_stable: paddr/pwdata/pwrite changed during transfer, required stable %h/%h/%b", tag, a, d, w); n_fail++;
        end
        if (rsp_err !== exp_err) begin
            $display("FAIL %s_err: rsp_err=%b required %b", tag, rsp_err, exp_err); n_fail++;
        end
        if (rsp_rdata !== exp_rd) begin
            $display("FAIL %s_rdata: rsp_rdata=%h required %h", tag, rsp_rdata, exp_rd); n_fail++;
        end
        if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL %s_rsp_cycle: psel=%b penable=%b cmd_ready=%b required 0 0 1", tag, psel, penable, cmd_ready); n_fail++;
        end
        @(negedge pclk);
        if (rsp_valid !== 1'b0) begin
            $display("FAIL %s_pulse: rsp_valid=%b one cycle later, required 0", tag, rsp_valid); n_fail++;
        end
        if (w && !exp_err) model_mem[a] = d;
    endtask

    task automatic test_reset;
        #12;
        n_checks += 3;
        if ({cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite} !== 6'b0) begin
            $display("FAIL reset_ctrl: ctrl=%b required 000000",
                     {cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite}); n_fail++;
        end
        if (paddr !== 8'h00 || pwdata !== 16'h0000 || rsp_rdata !== 16'h0000) begin
            $display("FAIL reset_data: paddr=%h pwdata=%h rsp_rdata=%h required 0", paddr, pwdata, rsp_rdata); n_fail++;
        end
        @(negedge pclk); rst = 1'b0; mem_clr = 1'b0;
        #1;
        if (cmd_ready !== 1'b0) begin
            $display("FAIL reset_release: cmd_ready=%b before first edge, required 0", cmd_ready); n_fail++;
        end
        @(negedge pclk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL reset_first_edge: cmd_ready=%b required 1", cmd_ready); n_fail++;
        end
    endtask

    task automatic test_write_read;
        run_xfer(1'b1, 8'h00, 16'hAA55, 0, "write0");
        run_xfer(1'b0, 8'h00, 16'h0000, 3, "read0_wait3");
        run_xfer(1'b1, 8'hFF, 16'h5A5A, 1, "write_ff");
        run_xfer(1'b0, 8'hFF, 16'h0000, 0, "read_ff");
    endtask

    task automatic test_back_to_back;
        bit seen = 0;
        bit ready_low = 1;
        wait_ready("b2b");
        wait_n = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h12; cmd_wdata = 16'h1234;
        @(posedge pclk); #1;
        cmd_write = 1'b0; cmd_addr = 8'h12; cmd_wdata = 16'($urandom);
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge pclk);
            if (rsp_valid) seen = 1;
            else if (cmd_ready !== 1'b0) ready_low = 0;
        end
        n_checks += 3;
        if (!ready_low) begin
            $display("FAIL b2b_ready_low: cmd_ready rose during first transfer, required 0"); n_fail++;
        end
        if (!seen || rsp_err !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL b2b_first_rsp: seen=%b err=%b cmd_ready=%b required 1 0 1", seen, rsp_err, cmd_ready); n_fail++;
        end
        @(posedge pclk); #1;
        if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 8'h12 || cmd_ready !== 1'b0) begin
            $display("FAIL b2b_second_accept: psel=%b penable=%b pwrite=%b paddr=%h cmd_ready=%b required 1 0 0 12 0",
                     psel, penable, pwrite, paddr, cmd_ready); n_fail++;
        end
        cmd_valid = 1'b0;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge pclk);
            if (rsp_valid) seen = 1;
        end
        n_checks++;
        if (!seen || rsp_rdata !== 16'h1234 || rsp_err !== 1'b0) begin
            $display("FAIL b2b_read: seen=%b rsp_rdata=%h err=%b required 1 1234 0", seen, rsp_rdata, rsp_err); n_fail++;
        end
        model_mem[8'h12] = 16'h1234;
    endtask

    task automatic test_timeout;
        run_xfer(1'b1, 8'h40, 16'hDEAD, 1000, "timeout_stall");
        run_xfer(1'b0, 8'h12, 16'h0000, 0, "after_timeout");
        run_xfer(1'b1, 8'h41, 16'hC0DE, TMO - 1, "ready_on_last");
        run_xfer(1'b0, 8'h41, 16'h0000, TMO, "timeout_exact");
        run_xfer(1'b0, 8'h41, 16'h0000, 2, "read_41");
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        wait_ready("rstmid");
        wait_n = 10;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_wdata = 16'hBEEF;
        @(negedge pclk); cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        #2 rst = 1'b1;
        #1;
        n_checks += 3;
        if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || paddr !== 8'h00) begin
            $display("FAIL rstmid_async: psel=%b penable=%b cmd_ready=%b rsp_valid=%b paddr=%h required 0 0 0 0 00",
                     psel, penable, cmd_ready, rsp_valid, paddr); n_fail++;
        end
        @(negedge pclk); rst = 1'b0; wait_n = 0;
        @(negedge pclk);
        if (cmd_ready !== 1'b1) begin
            $display("FAIL rstmid_ready: cmd_ready=%b one edge after release, required 1", cmd_ready); n_fail++;
        end
        repeat (4) begin
            if (rsp_valid) seen = 1;
            @(negedge pclk);
        end
        if (seen) begin
            $display("FAIL rstmid_no_rsp: rsp_valid=1 after reset, required 0"); n_fail++;
        end
        run_xfer(1'b0, 8'h33, 16'h0000, 0, "rstmid_read_dropped");
        run_xfer(1'b1, 8'h33, 16'h1357, 1, "rstmid_write");
        run_xfer(1'b0, 8'h33, 16'h0000, 0, "rstmid_read");
    endtask

    task automatic test_random;
        logic [7:0] a;
        int r, wn;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 3);
            a = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : (r == 2) ? 8'h12 : 8'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            wn = (r == 9) ? TMO + $urandom_range(0, 4) : (r == 8) ? TMO - 1 : r % 4;
            run_xfer(1'($urandom), a, 16'($urandom), wn, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1; wait_n = 0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 16'h0000;
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
        test_reset;
        test_write_read;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
